// File: rtl/cpuex_uart_pkg.sv
// Shared constants and helpers for the UART receive path.
// Holds byte width, default RX FIFO depth, statistics counter width and a saturating increment.
package cpuex_uart_pkg;

  localparam int unsigned BYTE_W                 = 8;
  localparam int unsigned RX_FIFO_DEPTH_LOG2_DEF = 4;
  localparam int unsigned STAT_W                 = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Storage array for uart_rx_fifo: synchronous write, asynchronous read.
// The array has no reset; the pointers in the parent decide which entries are meaningful.
module uart_rx_fifo_mem #(
  parameter int unsigned AddrW = 4,
  parameter int unsigned DataW = 8
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [DataW-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between uart_rx and the core: edge-detected capture, FWFT valid/pop output.
// Define UART_RX_FIFO_STATS_EN to add the ferr_count and drop_count statistics ports.
module uart_rx_fifo
  import cpuex_uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2_DEF,
  parameter int unsigned DROP_FERR  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BYTE_W-1:0]     rx_data,
  input  logic                  rx_ready,
  input  logic                  rx_ferr,
  input  logic                  clear,
  output logic [BYTE_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_pop,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
`ifdef UART_RX_FIFO_STATS_EN
  ,
  output logic [STAT_W-1:0]     ferr_count,
  output logic [STAT_W-1:0]     drop_count
`endif
);

  localparam int unsigned PtrW = DEPTH_LOG2 + 1;

  if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 10) begin : gen_bad_depth
    $error("uart_rx_fifo: DEPTH_LOG2 must be in 1..10");
  end

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic              rx_ready_q;
  logic              overflow_q, overflow_d;
  logic              rise, push_req, pop, empty, full, wr_en, drop;
  logic [BYTE_W-1:0] rd_data;

  assign rise     = rx_ready & ~rx_ready_q;
  assign push_req = rise & ~((DROP_FERR != 0) & rx_ferr);

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                 (wr_ptr_q[PtrW-2:0] == rd_ptr_q[PtrW-2:0]);
  assign pop   = out_pop & ~empty;

  // When full, a same-cycle pop frees the slot being written, so the push is still accepted.
  assign wr_en = push_req & (~full | pop) & ~clear;
  assign drop  = push_req & full & ~pop & ~clear;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (drop) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rx_ready_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rx_ready_q <= rx_ready;
      overflow_q <= overflow_d;
    end
  end

  uart_rx_fifo_mem #(
    .AddrW (DEPTH_LOG2),
    .DataW (BYTE_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[PtrW-2:0]),
    .wdata_i (rx_data),
    .raddr_i (rd_ptr_q[PtrW-2:0]),
    .rdata_o (rd_data)
  );

  assign out_valid = ~empty;
  assign out_data  = empty ? '0 : rd_data;
  assign count     = wr_ptr_q - rd_ptr_q;
  assign overflow  = overflow_q;

`ifdef UART_RX_FIFO_STATS_EN
  logic [STAT_W-1:0] ferr_cnt_q, ferr_cnt_d;
  logic [STAT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Framing errors are counted on every rising edge, independent of whether the byte is kept.
  always_comb begin
    ferr_cnt_d = ferr_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (clear) begin
      ferr_cnt_d = '0;
      drop_cnt_d = '0;
    end else begin
      if (rise & rx_ferr) begin
        ferr_cnt_d = sat_inc(ferr_cnt_q);
      end
      if (drop) begin
        drop_cnt_d = sat_inc(drop_cnt_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ferr_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      ferr_cnt_q <= ferr_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign ferr_count = ferr_cnt_q;
  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic vs a queue model.
// Works with or without UART_RX_FIFO_STATS_EN; default parameters (depth 16, DROP_FERR=1).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       rx_ferr = 1'b0;
  logic       clear = 1'b0;
  logic       out_pop = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic [4:0] count;
  logic       overflow;
`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0] ferr_count;
  logic [15:0] drop_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  uart_rx_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .rx_ferr   (rx_ferr),
    .clear     (clear),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_pop   (out_pop),
    .count     (count),
    .overflow  (overflow)
`ifdef UART_RX_FIFO_STATS_EN
    ,
    .ferr_count (ferr_count),
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input logic ferr);
    rx_data  = b;
    rx_ferr  = ferr;
    rx_ready = 1'b1;
    cycle();
    rx_ready = 1'b0;
    rx_ferr  = 1'b0;
    cycle();
  endtask

  task automatic pop_one();
    out_pop = 1'b1;
    cycle();
    out_pop = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({count, out_valid, out_data, overflow} !== 15'h0) begin
      $display("FAIL reset_async: got count=%0d valid=%b data=%h ovf=%b, want all 0",
               count, out_valid, out_data, overflow);
      n_fail++;
    end
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    n_cmp++;
    if ({count, out_valid, out_data, overflow} !== 15'h0) begin
      $display("FAIL reset_release: got count=%0d valid=%b data=%h ovf=%b, want all 0",
               count, out_valid, out_data, overflow);
      n_fail++;
    end
`ifdef UART_RX_FIFO_STATS_EN
    n_cmp++;
    if (ferr_count !== 16'h0 || drop_count !== 16'h0) begin
      $display("FAIL reset_stats: got ferr=%0d drop=%0d, want 0 0", ferr_count, drop_count);
      n_fail++;
    end
`endif
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) push_byte(8'h41 + 8'(i), 1'b0);
    n_cmp++;
    if (count !== 5'd3 || out_valid !== 1'b1 || out_data !== 8'h41) begin
      $display("FAIL basic_fill: got count=%0d valid=%b data=%h, want 3 1 41",
               count, out_valid, out_data);
      n_fail++;
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_data !== 8'h41 + 8'(i)) begin
        $display("FAIL basic_pop%0d: got %h, want %h", i, out_data, 8'h41 + 8'(i));
        n_fail++;
      end
      pop_one();
    end
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || count !== 5'd0) begin
      $display("FAIL basic_empty: got valid=%b data=%h count=%0d, want 0 00 0",
               out_valid, out_data, count);
      n_fail++;
    end
  endtask

  task automatic test_level_hold();
    do_clear();
    rx_data  = 8'h55;
    rx_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    rx_ready = 1'b0;
    cycle();
    n_cmp++;
    if (count !== 5'd1 || out_data !== 8'h55) begin
      $display("FAIL level_hold: got count=%0d data=%h, want 1 55", count, out_data);
      n_fail++;
    end
    pop_one();
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < 17; i++) push_byte(8'(i), 1'b0);
    n_cmp++;
    if (count !== 5'd16 || overflow !== 1'b1) begin
      $display("FAIL overflow_full: got count=%0d ovf=%b, want 16 1", count, overflow);
      n_fail++;
    end
`ifdef UART_RX_FIFO_STATS_EN
    n_cmp++;
    if (drop_count !== 16'd1) begin
      $display("FAIL overflow_drop_count: got %0d, want 1", drop_count);
      n_fail++;
    end
`endif
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (out_data !== 8'(i)) begin
        $display("FAIL overflow_drain%0d: got %h, want %h", i, out_data, 8'(i));
        n_fail++;
      end
      pop_one();
    end
    n_cmp++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      $display("FAIL overflow_after: got valid=%b ovf=%b, want 0 1", out_valid, overflow);
      n_fail++;
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp;
    do_clear();
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0);
    rx_data  = 8'hAA;
    rx_ready = 1'b1;
    out_pop  = 1'b1;
    cycle();
    rx_ready = 1'b0;
    out_pop  = 1'b0;
    cycle();
    n_cmp++;
    if (count !== 5'd16 || overflow !== 1'b0) begin
      $display("FAIL full_pushpop: got count=%0d ovf=%b, want 16 0", count, overflow);
      n_fail++;
    end
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 8'(i + 1) : 8'hAA;
      n_cmp++;
      if (out_data !== exp) begin
        $display("FAIL full_pushpop_drain%0d: got %h, want %h", i, out_data, exp);
        n_fail++;
      end
      pop_one();
    end
  endtask

  task automatic test_ferr();
    do_clear();
    push_byte(8'h7E, 1'b1);
    n_cmp++;
    if (count !== 5'd0 || out_valid !== 1'b0) begin
      $display("FAIL ferr_drop: got count=%0d valid=%b, want 0 0", count, out_valid);
      n_fail++;
    end
`ifdef UART_RX_FIFO_STATS_EN
    n_cmp++;
    if (ferr_count !== 16'd1) begin
      $display("FAIL ferr_count: got %0d, want 1", ferr_count);
      n_fail++;
    end
`endif
    push_byte(8'h3C, 1'b0);
    n_cmp++;
    if (count !== 5'd1 || out_data !== 8'h3C) begin
      $display("FAIL ferr_then_good: got count=%0d data=%h, want 1 3C", count, out_data);
      n_fail++;
    end
  endtask

  task automatic test_clear_reset();
    do_clear();
    for (int i = 0; i < 17; i++) push_byte(8'h20 + 8'(i), 1'b0);
    for (int i = 0; i < 12; i++) pop_one();
    n_cmp++;
    if (count !== 5'd4 || overflow !== 1'b1 || out_data !== 8'h2C) begin
      $display("FAIL clear_setup: got count=%0d ovf=%b data=%h, want 4 1 2C",
               count, overflow, out_data);
      n_fail++;
    end
    clear    = 1'b1;
    rx_data  = 8'h99;
    rx_ready = 1'b1;
    cycle();
    clear    = 1'b0;
    rx_ready = 1'b0;
    n_cmp++;
    if (count !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || out_data !== 8'h00) begin
      $display("FAIL clear_with_push: got count=%0d valid=%b ovf=%b data=%h, want 0 0 0 00",
               count, out_valid, overflow, out_data);
      n_fail++;
    end
`ifdef UART_RX_FIFO_STATS_EN
    n_cmp++;
    if (ferr_count !== 16'd0 || drop_count !== 16'd0) begin
      $display("FAIL clear_stats: got ferr=%0d drop=%0d, want 0 0", ferr_count, drop_count);
      n_fail++;
    end
`endif
    cycle();
    for (int i = 0; i < 3; i++) push_byte(8'h60 + 8'(i), 1'b0);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({count, out_valid, out_data, overflow} !== 15'h0) begin
      $display("FAIL reset_midstream: got count=%0d valid=%b data=%h ovf=%b, want all 0",
               count, out_valid, out_data, overflow);
      n_fail++;
    end
    cycle();
    rst = 1'b0;
    cycle();
    push_byte(8'h11, 1'b0);
    n_cmp++;
    if (count !== 5'd1 || out_data !== 8'h11) begin
      $display("FAIL after_reset_push: got count=%0d data=%h, want 1 11", count, out_data);
      n_fail++;
    end
  endtask

  // Reference: a byte queue of capacity 16 plus the last seen rx_ready level.
  task automatic test_random();
    logic [7:0] q[$];
    logic       prev_rdy;
    logic       ovf_m;
    logic       rise_m, push_m, pop_m;
    logic [7:0] exp_data;
    int         ferr_m, drop_m;
    do_clear();
    cycle();
    q.delete();
    prev_rdy = 1'b0;
    ovf_m    = 1'b0;
    ferr_m   = 0;
    drop_m   = 0;
    for (int c = 0; c < 600; c++) begin
      rx_ready = 1'($urandom_range(0, 1));
      rx_data  = 8'($urandom);
      rx_ferr  = ($urandom_range(0, 7) == 0);
      out_pop  = ($urandom_range(0, 3) < ((c % 200) < 100 ? 1 : 3));
      clear    = ($urandom_range(0, 79) == 0);
      rise_m   = rx_ready && !prev_rdy;
      push_m   = rise_m && !rx_ferr;
      pop_m    = out_pop && (q.size() > 0);
      if (clear) begin
        q.delete();
        ovf_m  = 1'b0;
        ferr_m = 0;
        drop_m = 0;
      end else begin
        if (rise_m && rx_ferr) ferr_m++;
        if (pop_m) void'(q.pop_front());
        if (push_m) begin
          if (q.size() < 16) q.push_back(rx_data);
          else begin
            ovf_m = 1'b1;
            drop_m++;
          end
        end
      end
      prev_rdy = rx_ready;
      cycle();
      exp_data = (q.size() > 0) ? q[0] : 8'h00;
      n_cmp++;
      if (count !== 5'(q.size()) || out_valid !== (q.size() > 0) || out_data !== exp_data ||
          overflow !== ovf_m) begin
        $display("FAIL random_c%0d: got count=%0d valid=%b data=%h ovf=%b, want %0d %b %h %b",
                 c, count, out_valid, out_data, overflow, q.size(), q.size() > 0, exp_data,
                 ovf_m);
        n_fail++;
      end
`ifdef UART_RX_FIFO_STATS_EN
      n_cmp++;
      if (ferr_count !== 16'(ferr_m) || drop_count !== 16'(drop_m)) begin
        $display("FAIL random_stats_c%0d: got ferr=%0d drop=%0d, want %0d %0d",
                 c, ferr_count, drop_count, ferr_m, drop_m);
        n_fail++;
      end
`endif
    end
    rx_ready = 1'b0;
    out_pop  = 1'b0;
    clear    = 1'b0;
    rx_ferr  = 1'b0;
    cycle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_level_hold();
    test_overflow();
    test_full_push_pop();
    test_ferr();
    test_clear_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
